// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: forward selects, shadow slots,
// and the forwarding compare used for both ALU operands.
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

    // Execute slot keeps sources for forwarding and ResultSrc for load detection
    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       reg_write;
        logic [1:0] result_src;
    } ex_slot_t;

    typedef struct packed {
        logic [4:0] rd;
        logic       reg_write;
    } wr_slot_t;

    // Memory stage wins over Writeback; x0 is hardwired and never forwarded
    function automatic fwd_sel_e fwd_sel(input logic [4:0] rs_e,
                                         input wr_slot_t m,
                                         input wr_slot_t w);
        fwd_sel_e sel;
        sel = FWD_RF;
        if (rs_e != 5'd0 && m.reg_write && m.rd == rs_e)
            sel = FWD_MEM;
        else if (rs_e != 5'd0 && w.reg_write && w.rd == rs_e)
            sel = FWD_WB;
        return sel;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && cnt_q != {WIDTH{1'b1}})
            cnt_d = cnt_q + WIDTH'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign count = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller: shadows E/M/W register fields to drive ALU forwarding,
// load-use stalls and branch flushes, plus saturating stall/flush counters.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [4:0]           Rs1D,
    input  logic [4:0]           Rs2D,
    input  logic [4:0]           RdD,
    input  logic                 RegWriteD,
    input  logic [1:0]           ResultSrcD,
    input  logic                 PCSrcE,
    output logic                 StallF,
    output logic                 StallD,
    output logic                 FlushD,
    output logic                 FlushE,
    output logic [1:0]           ForwardAE,
    output logic [1:0]           ForwardBE,
    output logic [CNT_WIDTH-1:0] stall_cnt,
    output logic [CNT_WIDTH-1:0] flush_cnt
);

    ex_slot_t e_q, e_d;
    wr_slot_t m_q, m_d, w_q, w_d;
    logic     lw_stall;

    always_comb begin
        lw_stall = (e_q.result_src == RESULT_SRC_LOAD) && (e_q.rd != 5'd0) &&
                   (e_q.rd == Rs1D || e_q.rd == Rs2D);
        // A taken branch makes the Decode instruction wrong-path, so it is flushed, not held
        StallF    = lw_stall && !PCSrcE;
        StallD    = lw_stall && !PCSrcE;
        FlushD    = PCSrcE;
        FlushE    = PCSrcE || lw_stall;
        ForwardAE = fwd_sel(e_q.rs1, m_q, w_q);
        ForwardBE = fwd_sel(e_q.rs2, m_q, w_q);
    end

    always_comb begin
        e_d = '{rs1: Rs1D, rs2: Rs2D, rd: RdD, reg_write: RegWriteD, result_src: ResultSrcD};
        if (FlushE) e_d = '0;
        m_d = '{rd: e_q.rd, reg_write: e_q.reg_write};
        w_d = m_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_q <= '0;
            m_q <= '0;
            w_q <= '0;
        end else begin
            e_q <= e_d;
            m_q <= m_d;
            w_q <= w_d;
        end
    end

    sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (StallD),
        .count (stall_cnt)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (PCSrcE),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: per-cycle expectations queued at drive time,
// popped and compared at the falling edge.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] Rs1D, Rs2D, RdD;
    logic       RegWriteD;
    logic [1:0] ResultSrcD;
    logic       PCSrcE;
    logic       StallF, StallD, FlushD, FlushE;
    logic [1:0] ForwardAE, ForwardBE;
    logic [2:0] stall_cnt, flush_cnt;

    typedef struct {
        logic       stf, std, fld, fle;
        logic [1:0] fa, fb;
        logic [2:0] sc, fc;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   step_n = 0;

    hazard_ctrl #(.CNT_WIDTH(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .Rs1D       (Rs1D),
        .Rs2D       (Rs2D),
        .RdD        (RdD),
        .RegWriteD  (RegWriteD),
        .ResultSrcD (ResultSrcD),
        .PCSrcE     (PCSrcE),
        .StallF     (StallF),
        .StallD     (StallD),
        .FlushD     (FlushD),
        .FlushE     (FlushE),
        .ForwardAE  (ForwardAE),
        .ForwardBE  (ForwardBE),
        .stall_cnt  (stall_cnt),
        .flush_cnt  (flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        n_chk++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL step %0d %s: got %0h expected %0h", step_n, tag, obs, exp_v);
        end
    endtask

    task automatic push_exp(input logic stf, std, fld, fle, input logic [1:0] fa, fb,
                            input logic [2:0] sc, fc);
        exp_t e;
        e.stf = stf; e.std = std; e.fld = fld; e.fle = fle;
        e.fa = fa; e.fb = fb; e.sc = sc; e.fc = fc;
        exp_q.push_back(e);
    endtask

    task automatic compare_out();
        exp_t e;
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 8'd1, 8'd0);
            return;
        end
        e = exp_q.pop_front();
        chk("StallF",    {7'd0, StallF}, {7'd0, e.stf});
        chk("StallD",    {7'd0, StallD}, {7'd0, e.std});
        chk("FlushD",    {7'd0, FlushD}, {7'd0, e.fld});
        chk("FlushE",    {7'd0, FlushE}, {7'd0, e.fle});
        chk("ForwardAE", {6'd0, ForwardAE}, {6'd0, e.fa});
        chk("ForwardBE", {6'd0, ForwardBE}, {6'd0, e.fb});
        chk("stall_cnt", {5'd0, stall_cnt}, {5'd0, e.sc});
        chk("flush_cnt", {5'd0, flush_cnt}, {5'd0, e.fc});
    endtask

    // One cycle: drive the Decode-side inputs, queue the expected outputs, check at negedge
    task automatic step(input logic [4:0] rs1, rs2, rd, input logic rw, input logic [1:0] src,
                        input logic pc, input logic stf, std, fld, fle,
                        input logic [1:0] fa, fb, input logic [2:0] sc, fc);
        @(posedge clk);
        #1;
        step_n++;
        Rs1D = rs1; Rs2D = rs2; RdD = rd; RegWriteD = rw; ResultSrcD = src; PCSrcE = pc;
        push_exp(stf, std, fld, fle, fa, fb, sc, fc);
        @(negedge clk);
        compare_out();
    endtask

    initial begin
        rst_n = 1'b0;
        Rs1D = '0; Rs2D = '0; RdD = '0; RegWriteD = 1'b0; ResultSrcD = '0; PCSrcE = 1'b0;
        #2;
        push_exp(0, 0, 0, 0, 2'b00, 2'b00, 3'd0, 3'd0);
        compare_out();
        #1 rst_n = 1'b1;

        // back-to-back ALU dependency: add x5 ; sub x6,x5,x1
        step(5'd1, 5'd2, 5'd5, 1, 2'b00, 0,  0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
        step(5'd5, 5'd1, 5'd6, 1, 2'b00, 0,  0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
        step(5'd0, 5'd0, 5'd0, 0, 2'b00, 0,  0, 0, 0, 0, 2'b10, 2'b00, 0, 0);
        step(5'd0, 5'd0, 5'd0, 0, 2'b00, 0,  0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
        // writeback forwarding: writer x7, unrelated, reader of x7 in rs2
        step(5'd0, 5'd0, 5'd7, 1, 2'b00, 0,  0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
        step(5'd1, 5'd2, 5'd8, 1, 2'b00, 0,  0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
        step(5'd1, 5'd7, 5'd9, 1, 2'b00, 0,  0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
        // priority: two writers of x7 then a reader
        step(5'd0, 5'd0, 5'd7, 1, 2'b00, 0,  0, 0, 0, 0, 2'b00, 2'b01, 0, 0);
        step(5'd0, 5'd0, 5'd7, 1, 2'b00, 0,  0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
        step(5'd7, 5'd7, 5'd10, 1, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
        step(5'd0, 5'd0, 5'd0, 0, 2'b00, 0,  0, 0, 0, 0, 2'b10, 2'b10, 0, 0);
        // x0 guard: writer of x0, reader of x0, load to x0 followed by x0 reader
        step(5'd0, 5'd0, 5'd0, 1, 2'b00, 0,  0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
        step(5'd0, 5'd0, 5'd11, 1, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
        step(5'd0, 5'd0, 5'd0, 1, 2'b01, 0,  0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
        step(5'd0, 5'd0, 5'd0, 0, 2'b00, 0,  0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
        // load-use: lw x3 ; add x4,x3,x3 (held in D during the stall)
        step(5'd2, 5'd0, 5'd3, 1, 2'b01, 0,  0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
        step(5'd3, 5'd3, 5'd4, 1, 2'b00, 0,  1, 1, 0, 1, 2'b00, 2'b00, 0, 0);
        step(5'd3, 5'd3, 5'd4, 1, 2'b00, 0,  0, 0, 0, 0, 2'b00, 2'b00, 1, 0);
        step(5'd0, 5'd0, 5'd0, 0, 2'b00, 0,  0, 0, 0, 0, 2'b01, 2'b01, 1, 0);
        // branch coincident with load-use: branch wins, no stall counted
        step(5'd0, 5'd0, 5'd3, 1, 2'b01, 0,  0, 0, 0, 0, 2'b00, 2'b00, 1, 0);
        step(5'd3, 5'd3, 5'd4, 1, 2'b00, 1,  0, 0, 1, 1, 2'b00, 2'b00, 1, 0);
        step(5'd0, 5'd0, 5'd0, 0, 2'b00, 0,  0, 0, 0, 0, 2'b00, 2'b00, 1, 1);
        // flush counter saturation at 7 with PCSrcE held high
        for (int k = 0; k < 10; k++) begin
            logic [2:0] fc_e;
            fc_e = (k + 1 > 7) ? 3'd7 : 3'(k + 1);
            step(5'd0, 5'd0, 5'd0, 0, 2'b00, 1, 0, 0, 1, 1, 2'b00, 2'b00, 1, fc_e);
        end
        step(5'd0, 5'd0, 5'd0, 0, 2'b00, 0,  0, 0, 0, 0, 2'b00, 2'b00, 1, 7);
        // set up a stall, then reset in the middle of it
        step(5'd0, 5'd0, 5'd3, 1, 2'b01, 0,  0, 0, 0, 0, 2'b00, 2'b00, 1, 7);
        step(5'd3, 5'd3, 5'd4, 1, 2'b00, 0,  1, 1, 0, 1, 2'b00, 2'b00, 1, 7);
        #1 rst_n = 1'b0;
        #1;
        step_n++;
        push_exp(0, 0, 0, 0, 2'b00, 2'b00, 3'd0, 3'd0);
        compare_out();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the five-stage core. It keeps a shadow copy of the destination and source register fields for the Execute, Memory and Writeback stages. From these it generates operand-forwarding selects for the Execute ALU, the load-use stall, and the control-hazard flushes. `FlushE` drives the flush input of the Decode→Execute register. Saturating stall and flush event counters are kept for performance measurement.

## Interface
- `CNT_WIDTH`, 32: width of each saturating event counter.
- `clk`  in  1  core clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `Rs1D`, `Rs2D`  in  5 each  source register indices of the instruction in Decode.
- `RdD`  in  5  destination index of the instruction in Decode.
- `RegWriteD`  in  1  Decode instruction writes the register file.
- `ResultSrcD`  in  2  Decode result source; `2'b01` marks a load.
- `PCSrcE`  in  1  taken branch or jump resolved in Execute.
- `StallF`, `StallD`  out  1 each  hold the PC register and the Fetch→Decode register.
- `FlushD`  out  1  clear the Fetch→Decode register.
- `FlushE`  out  1  clear the Decode→Execute register.
- `ForwardAE`, `ForwardBE`  out  2 each  ALU operand A/B source: `00` register file, `10` Memory-stage ALU result, `01` Writeback result.
- `stall_cnt`  out  CNT_WIDTH  cycles with load-use stall active.
- `flush_cnt`  out  CNT_WIDTH  cycles with `PCSrcE` high.

## Operation
- **Shadow state:** E-slot {Rs1, Rs2, Rd, RegWrite, ResultSrc}, M-slot {Rd, RegWrite}, W-slot {Rd, RegWrite}.
- **Advance every cycle:**
  - W ← M and M ← E.
  - E ← D-side inputs, unless `FlushE` is high. In that case E ← bubble (all fields 0).
- **Forwarding, operand A** (operand B is identical with Rs2):
  - `10` if Rs1E ≠ 0, RegWriteM = 1 and RdM = Rs1E.
  - Otherwise `01` if Rs1E ≠ 0, RegWriteW = 1 and RdW = Rs1E.
  - Otherwise `00`.
  - M has priority over W. x0 is never forwarded.
- **Load-use:** `lwStall` = (ResultSrcE = `01`) & (RdE ≠ 0) & (RdE = Rs1D | RdE = Rs2D).
- **Stall and flush outputs:**
  - `StallF` = `StallD` = `lwStall` & ~`PCSrcE`.
  - `FlushD` = `PCSrcE`.
  - `FlushE` = `PCSrcE` | `lwStall`.
- **Simultaneous branch and load-use:** the branch wins. The instruction in D is wrong-path, so no stall is raised. D and E are both flushed. Only `flush_cnt` increments.
- **Counters:**
  - `stall_cnt` +1 on each cycle `StallD` = 1.
  - `flush_cnt` +1 on each cycle `PCSrcE` = 1.
  - Both saturate at all-ones and never wrap.
- **Reset:**
  - Asynchronous assertion clears all shadow slots to bubble and both counters to 0.
  - Outputs derived from cleared state: all stall/flush outputs 0 (given `PCSrcE` = 0), forward selects `00`.
  - Reset mid-stall drops the stall immediately.

## Timing
- Stall, flush and forward outputs are combinational from current inputs and shadow state: zero-cycle latency.
- Shadow state and counters update one cycle after the inputs.
- A load-use stall lasts exactly one cycle. The bubble entered into E clears the `lwStall` condition on the next cycle, and the dependent instruction then receives `01` forwarding from W two cycles later.
- A branch flush lasts one cycle per `PCSrcE` pulse.
- A counter increment is visible the cycle after the event.

## Structure
- `hazard_pkg` holds:
  - forward-select enum (`FWD_RF` = `2'b00`, `FWD_WB` = `2'b01`, `FWD_MEM` = `2'b10`);
  - `RESULT_SRC_LOAD` = `2'b01`;
  - a shadow-slot struct type.
- Sub-module `sat_counter` (parameterised width, `inc` input) is instantiated twice for the event counters.
- Forwarding compare logic is written once as a function in `hazard_pkg` and used for both operands.

## Test plan
- **Back-to-back ALU dependency:** `add x5,…` then `sub x6,x5,x1` → in the `sub` Execute cycle, `ForwardAE` = `10`, `ForwardBE` = `00`.
- **Writeback forwarding and priority:**
  - Writer to x7, one unrelated instruction, then reader of x7 in rs2 → `ForwardBE` = `01`.
  - Writers to x7 in both M and W → `10`.
- **x0 guard:** writer with RdD = 0 and RegWriteD = 1, followed by a reader of x0 → forward selects stay `00`, no stall.
- **Load-use:** `lw x3` then `add x4,x3,x3`:
  - one cycle with `StallF` = `StallD` = `FlushE` = 1;
  - the next cycle has no stall;
  - two cycles later `ForwardAE` = `ForwardBE` = `01`;
  - `stall_cnt` = 1.
- **Branch coincident with load-use:** `PCSrcE` = 1 → `FlushD` = `FlushE` = 1, `StallD` = 0, `flush_cnt` +1, `stall_cnt` unchanged.
- **Saturation and reset:**
  - With `CNT_WIDTH` = 3, hold `PCSrcE` high for 10 cycles → `flush_cnt` stops at 7.
  - Assert `rst_n` = 0 mid-cycle → counters read 0 immediately and all outputs return to reset values.
